// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - boot copier: SPI flash READ (0x03) stream packed into 32-bit ramio word writes
module flash_loader #(
  parameter int          TransferBytes     = 4096,
  parameter logic [23:0] FlashStartAddress = 24'h000000,
  parameter logic [31:0] RamStartAddress   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ramio_enable,
  output logic [1:0]  ramio_write_type,
  output logic [2:0]  ramio_read_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy,
  output logic        flash_clk,
  output logic        flash_cs,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  localparam logic [31:0] LastWord = 32'(TransferBytes / 4 - 1);

  typedef enum logic [2:0] {
    IDLE, CS_LOW, CMD, ADDR, RECV, WRITE, WAIT_WR, FINISH
  } state_t;

  state_t      state, state_next;
  logic        phase;
  logic [4:0]  bit_cnt;
  logic [4:0]  last_bit;
  logic [1:0]  byte_idx;
  logic [31:0] shreg;
  logic [6:0]  rx_bits;
  logic        ignore;
  logic [31:0] word_cnt;
  logic [31:0] address;
  logic [31:0] data;
  logic        done_q;
  logic        spi_active;
  logic        bit_end;

  assign ramio_read_type = 3'b000;
  assign ramio_address   = address;
  assign ramio_data_in   = data;
  assign done            = done_q;

  always_comb begin
    state_next       = state;
    busy             = 1'b0;
    flash_cs         = 1'b1;
    flash_clk        = 1'b0;
    flash_mosi       = 1'b0;
    ramio_enable     = 1'b0;
    ramio_write_type = 2'b00;
    spi_active       = 1'b0;
    last_bit         = (state == ADDR) ? 5'd23 : 5'd7;
    bit_end          = phase && (bit_cnt == last_bit);
    case (state)
      IDLE: if (start) state_next = CS_LOW;
      CS_LOW: begin
        busy       = 1'b1;
        flash_cs   = 1'b0;
        state_next = CMD;
      end
      CMD, ADDR: begin
        busy       = 1'b1;
        flash_cs   = 1'b0;
        spi_active = 1'b1;
        flash_clk  = phase;
        flash_mosi = shreg[31];
        if (bit_end) state_next = (state == CMD) ? ADDR : RECV;
      end
      RECV: begin
        busy       = 1'b1;
        flash_cs   = 1'b0;
        spi_active = 1'b1;
        flash_clk  = phase;
        if (bit_end && byte_idx == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        flash_cs = 1'b0;
        if (!ramio_busy) begin
          ramio_enable     = 1'b1;
          ramio_write_type = 2'b11;
          state_next       = WAIT_WR;
        end
      end
      WAIT_WR: begin
        // busy on the cycle right after acceptance may be stale, so it is skipped
        busy     = 1'b1;
        flash_cs = 1'b0;
        if (!ignore && !ramio_busy) state_next = (word_cnt == LastWord) ? FINISH : RECV;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 1'b0;
      bit_cnt  <= 5'd0;
      byte_idx <= 2'd0;
      shreg    <= 32'd0;
      rx_bits  <= 7'd0;
      ignore   <= 1'b0;
      word_cnt <= 32'd0;
      address  <= 32'd0;
      data     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            done_q   <= 1'b0;
            word_cnt <= 32'd0;
            address  <= RamStartAddress;
            shreg    <= {8'h03, FlashStartAddress};
            phase    <= 1'b0;
            bit_cnt  <= 5'd0;
            byte_idx <= 2'd0;
          end
        end
        CMD, ADDR: if (phase) shreg <= {shreg[30:0], 1'b0};
        RECV: begin
          if (phase) begin
            rx_bits <= {rx_bits[5:0], flash_miso};
            if (bit_cnt == 5'd7) begin
              data[{byte_idx, 3'b000} +: 8] <= {rx_bits, flash_miso};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: if (!ramio_busy) ignore <= 1'b1;
        WAIT_WR: begin
          ignore <= 1'b0;
          if (!ignore && !ramio_busy) begin
            if (word_cnt == LastWord) begin
              done_q <= 1'b1;
            end else begin
              address  <= address + 32'd4;
              word_cnt <= word_cnt + 32'd1;
            end
          end
        end
        default: ;
      endcase
      if (spi_active) begin
        phase <= ~phase;
        if (phase) bit_cnt <= (bit_cnt == last_bit) ? 5'd0 : bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - flash_loader bench: flash + RAM models, per-cycle compare, directed and random runs
module tb_flash_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic rbusy0 = 1'b0, rbusy1 = 1'b0;

  logic [1:0]       busy_v, done_v, en_v, fclk_v, fcs_v, mosi_v;
  logic [1:0]       miso_v = 2'b00;
  logic [1:0][1:0]  wt_v;
  logic [1:0][2:0]  rt_v;
  logic [1:0][31:0] addr_v, data_v;
  logic [1:0]       rst_v, start_v, rbusy_v;
  assign rst_v   = {rst1, rst0};
  assign start_v = {start1, start0};
  assign rbusy_v = {rbusy1, rbusy0};

  flash_loader #(.TransferBytes(8)) dut_small (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy_v[0]), .done(done_v[0]),
    .ramio_enable(en_v[0]), .ramio_write_type(wt_v[0]), .ramio_read_type(rt_v[0]),
    .ramio_address(addr_v[0]), .ramio_data_in(data_v[0]), .ramio_busy(rbusy0),
    .flash_clk(fclk_v[0]), .flash_cs(fcs_v[0]), .flash_mosi(mosi_v[0]), .flash_miso(miso_v[0])
  );

  flash_loader #(.TransferBytes(4096)) dut_full (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy_v[1]), .done(done_v[1]),
    .ramio_enable(en_v[1]), .ramio_write_type(wt_v[1]), .ramio_read_type(rt_v[1]),
    .ramio_address(addr_v[1]), .ramio_data_in(data_v[1]), .ramio_busy(rbusy1),
    .flash_clk(fclk_v[1]), .flash_cs(fcs_v[1]), .flash_mosi(mosi_v[1]), .flash_miso(miso_v[1])
  );

  logic [7:0]  image [4096];
  logic [31:0] ram [2][1024];
  logic [31:0] cmdaddr [2];
  int          rxb [2];
  logic [1:0]  fp = 2'b00;
  int          n_cmp = 0, n_bad = 0;
  int          wr_cnt [2];
  int          wr_s [2][4];
  int          acc_s [2];
  int          sample = 0;
  logic        stop = 1'b0;
  int          nwords [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {image[4*i+3], image[4*i+2], image[4*i+1], image[4*i]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // SPI flash: captures 32 command/address bits on rising edges, then streams the image MSB first
  always @(fclk_v or fcs_v) begin : flash_model
    int idx;
    logic [7:0] b;
    for (int g = 0; g < 2; g++) begin
      if (fcs_v[g]) begin
        rxb[g] = 0;
        miso_v[g] = 1'b0;
        fp[g] = 1'b0;
      end else begin
        if (fclk_v[g] && !fp[g]) begin
          if (rxb[g] < 32) cmdaddr[g] = {cmdaddr[g][30:0], mosi_v[g]};
          rxb[g]++;
        end else if (!fclk_v[g] && fp[g] && rxb[g] >= 32) begin
          idx = rxb[g] - 32;
          if (idx / 8 < 4096) begin
            b = image[idx / 8];
            miso_v[g] = b[7 - idx % 8];
          end
        end
        fp[g] = fclk_v[g];
      end
    end
  end

  task automatic monitor;
    logic [1:0] pclk, pen, acc_pend;
    pclk = 2'b00; pen = 2'b00; acc_pend = 2'b00;
    while (!stop) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst_v[g]) begin
          chk("rst_busy", 32'(busy_v[g]), 0);
          chk("rst_done", 32'(done_v[g]), 0);
          chk("rst_enable", 32'(en_v[g]), 0);
          chk("rst_write_type", 32'(wt_v[g]), 0);
          chk("rst_address", addr_v[g], 0);
          chk("rst_data", data_v[g], 0);
          chk("rst_flash_clk", 32'(fclk_v[g]), 0);
          chk("rst_flash_cs", 32'(fcs_v[g]), 1);
          chk("rst_mosi", 32'(mosi_v[g]), 0);
          pclk[g] = 1'b0; pen[g] = 1'b0; acc_pend[g] = 1'b0;
        end else begin
          chk("read_type", 32'(rt_v[g]), 0);
          chk("write_type", 32'(wt_v[g]), en_v[g] ? 32'd3 : 32'd0);
          chk("cs_vs_busy", 32'(fcs_v[g]), 32'(!busy_v[g]));
          if (busy_v[g]) chk("done_while_busy", 32'(done_v[g]), 0);
          if (pclk[g]) chk("flash_clk_high_one_cycle", 32'(fclk_v[g]), 0);
          if (acc_pend[g]) begin
            chk("start_sets_busy", 32'(busy_v[g]), 1);
            chk("start_clears_done", 32'(done_v[g]), 0);
          end
          acc_pend[g] = 1'b0;
          if (start_v[g] && !busy_v[g]) begin
            wr_cnt[g] = 0;
            acc_s[g] = sample;
            acc_pend[g] = 1'b1;
          end
          if (en_v[g]) begin
            chk("wr_single_cycle", 32'(pen[g]), 0);
            chk("wr_while_ramio_busy", 32'(rbusy_v[g]), 0);
            chk("wr_flash_clk_paused", 32'(fclk_v[g]), 0);
            chk("wr_overflow", 32'(wr_cnt[g] < nwords[g]), 1);
            chk("wr_address", addr_v[g], 32'(4 * wr_cnt[g]));
            chk("wr_data", data_v[g], word_of(wr_cnt[g]));
            if (wr_cnt[g] < 1024) ram[g][wr_cnt[g]] = data_v[g];
            if (wr_cnt[g] < 4) wr_s[g][wr_cnt[g]] = sample;
            wr_cnt[g]++;
          end
          pclk[g] = fclk_v[g];
          pen[g] = en_v[g];
        end
      end
      sample++;
    end
  endtask

  task automatic seq_small;
    // plain copy, no ramio stalls: data, command bits and latency pinned by hand
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 2000 && !done_v[0]; i++) tick;
    chk("run1_done", 32'(done_v[0]), 1);
    chk("run1_busy", 32'(busy_v[0]), 0);
    chk("run1_cs", 32'(fcs_v[0]), 1);
    chk("run1_writes", 32'(wr_cnt[0]), 2);
    chk("run1_word0", ram[0][0], 32'h00010113);
    chk("run1_word1", ram[0][1], 32'h004000EF);
    chk("run1_cmd_addr", cmdaddr[0], 32'h03000000);
    chk("run1_first_latency", 32'(wr_s[0][0] - acc_s[0]), 130);
    chk("run1_word_latency", 32'(wr_s[0][1] - wr_s[0][0]), 67);
    repeat (3) tick;

    // ramio busy at the first Write
    ram[0][0] = 32'h0; ram[0][1] = 32'h0;
    rbusy0 = 1'b1;
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 400 && rxb[0] < 64; i++) tick;
    chk("stall_reach_write", 32'(rxb[0] >= 64), 1);
    repeat (5) tick;
    for (int i = 0; i < 20; i++) begin
      chk("stall_enable", 32'(en_v[0]), 0);
      chk("stall_flash_clk", 32'(fclk_v[0]), 0);
      tick;
    end
    rbusy0 = 1'b0;
    #1;
    chk("stall_release_enable", 32'(en_v[0]), 1);
    for (int i = 0; i < 2000 && !done_v[0]; i++) tick;
    chk("stall_done", 32'(done_v[0]), 1);
    chk("stall_writes", 32'(wr_cnt[0]), 2);
    chk("stall_word0", ram[0][0], 32'h00010113);
    chk("stall_word1", ram[0][1], 32'h004000EF);
    repeat (3) tick;

    // start while busy is ignored; start after done clears done
    chk("run3_done_before", 32'(done_v[0]), 1);
    start0 = 1'b1; tick; start0 = 1'b0; tick;
    chk("run3_done_cleared", 32'(done_v[0]), 0);
    chk("run3_busy", 32'(busy_v[0]), 1);
    repeat (50) tick;
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 2000 && !done_v[0]; i++) tick;
    chk("run3_done", 32'(done_v[0]), 1);
    chk("run3_writes", 32'(wr_cnt[0]), 2);
    repeat (3) tick;

    // random ramio stalls
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int i = 0; i < 4000 && !done_v[0]; i++) begin
      rbusy0 = ($urandom_range(0, 2) == 0);
      tick;
    end
    rbusy0 = 1'b0;
    chk("run4_done", 32'(done_v[0]), 1);
    chk("run4_writes", 32'(wr_cnt[0]), 2);
  endtask

  task automatic seq_full;
    start1 = 1'b1; tick; start1 = 1'b0;
    for (int i = 0; i < 1000 && wr_cnt[1] < 2; i++) tick;
    chk("abort_two_words", 32'(wr_cnt[1]), 2);
    repeat (30) tick;
    rst1 = 1'b1;
    #1;
    chk("abort_cs", 32'(fcs_v[1]), 1);
    chk("abort_busy", 32'(busy_v[1]), 0);
    chk("abort_done", 32'(done_v[1]), 0);
    chk("abort_enable", 32'(en_v[1]), 0);
    chk("abort_flash_clk", 32'(fclk_v[1]), 0);
    chk("abort_address", addr_v[1], 0);
    chk("abort_data", data_v[1], 0);
    repeat (4) tick;
    rst1 = 1'b0;
    repeat (20) tick;
    chk("abort_no_more_writes", 32'(wr_cnt[1]), 2);
    chk("abort_done_low", 32'(done_v[1]), 0);

    start1 = 1'b1; tick; start1 = 1'b0;
    for (int i = 0; i < 85000 && !done_v[1]; i++) begin
      rbusy1 = ($urandom_range(0, 7) == 0);
      tick;
    end
    rbusy1 = 1'b0;
    chk("full_done", 32'(done_v[1]), 1);
    chk("full_busy", 32'(busy_v[1]), 0);
    chk("full_writes", 32'(wr_cnt[1]), 1024);
    chk("full_cmd_addr", cmdaddr[1], 32'h03000000);
    for (int i = 0; i < 1024; i++) chk("full_readback", ram[1][i], word_of(i));
  endtask

  initial begin
    nwords[0] = 2;
    nwords[1] = 1024;
    for (int i = 0; i < 4096; i++) image[i] = 8'($urandom);
    image[0] = 8'h13; image[1] = 8'h01; image[2] = 8'h01; image[3] = 8'h00;
    image[4] = 8'hEF; image[5] = 8'h00; image[6] = 8'h40; image[7] = 8'h00;
    for (int g = 0; g < 2; g++) begin
      wr_cnt[g] = 0;
      acc_s[g] = 0;
      cmdaddr[g] = 32'h0;
      for (int k = 0; k < 4; k++) wr_s[g][k] = 0;
    end
    fork
      monitor();
      begin
        repeat (3) tick;
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick;
        fork
          seq_small();
          seq_full();
        join
        stop = 1'b1;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Boot-time copier that streams a program image from SPI flash into RAM through the `ramio` port.
- Sits upstream of `ramio`, in front of the `core`, and owns the ramio port until `done`; top level muxes ramio to `core` afterwards.
- Reads bytes with the standard READ command (0x03), packs 4 bytes little-endian into a 32-bit word and issues one word write per 4 bytes.

Parameters:
- TransferBytes, 4096, bytes copied; multiple of 4, minimum 4.
- FlashStartAddress, 0, 24-bit flash byte address sent after the command.
- RamStartAddress, 0, ramio byte address of the first word; word-aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- busy  out  1  high from start acceptance until done
- done  out  1  sticky high after the last word write completes; cleared by the next accepted start
- ramio_enable  out  1  write request strobe
- ramio_write_type  out  2  00 none, 01 byte, 10 half, 11 word; this block drives only 00 or 11
- ramio_read_type  out  3  constant 000
- ramio_address  out  32  byte address of the current word
- ramio_data_in  out  32  word to write
- ramio_busy  in  1  ramio cannot accept a request
- flash_clk  out  1  SPI clock, mode 0, frequency clk/2
- flash_cs  out  1  chip select, active low
- flash_mosi  out  1  command/address bits, MSB first
- flash_miso  in  1  data bits, MSB first

Behaviour:
- Reset (asynchronous, any state): state Idle, busy=0, done=0, ramio_enable=0, ramio_write_type=00, ramio_address=0, ramio_data_in=0, flash_clk=0, flash_cs=1, flash_mosi=0, internal counters 0.
- SPI bit timing: 2 clk cycles per bit.
  - Phase L: flash_clk=0; mosi driven with the current bit.
  - Phase H: flash_clk=1; miso is sampled on the clk edge that ends phase H and returns flash_clk to 0.
  - The SPI clock is paused, with flash_clk held 0, whenever the block waits on ramio.
- States:
  - Idle: start=1 -> CsLow. busy=1, done=0, word counter=0, ramio_address=RamStartAddress.
  - start while busy=1 is ignored.
  - CsLow: flash_cs=0 for one cycle with flash_clk=0 -> Cmd.
  - Cmd: shift out 8 bits, 0x03 -> Addr.
  - Addr: shift out the 24 bits of FlashStartAddress -> Recv.
  - Recv: shift in 8 bits; after the 8th bit the byte is placed at bits [8*k+7:8*k] of the word register, k = byte index 0..3.
    - k<3 -> remain in Recv, k++.
    - k=3 -> Write.
  - Write: wait until ramio_busy=0, then drive ramio_enable=1, write_type=11, address, data for exactly one cycle (acceptance cycle) -> WaitWr.
  - WaitWr:
    - ramio_enable=0, write_type=00.
    - Ignore ramio_busy on the cycle immediately after acceptance, then wait for ramio_busy=0.
    - If words remain: address += 4, k=0 -> Recv. flash_cs stays low, so the flash continues the sequential read.
    - Otherwise -> Finish.
  - Finish: flash_cs=1, flash_clk=0, busy=0, done=1 -> Idle.
- Exactly TransferBytes/4 writes per transfer, at ascending addresses RamStartAddress + 4*i; address arithmetic is 32-bit, with no wrap handling required.
- The ramio write data and address are held stable whenever ramio_enable=1.
- rst asserted mid-transfer aborts immediately:
  - flash_cs returns high asynchronously.
  - No further ramio writes are issued.
  - done stays 0.
- Latency per word, ramio never busy: 64 clk cycles for SPI + 1 acceptance cycle + 1 ignore cycle + 1 cycle for busy=0 observation.

Test Plan:
- TransferBytes=8, flash bytes 0x13,0x01,0x01,0x00,0xEF,0x00,0x40,0x00 -> exactly two word writes: [0x0]=0x00010113, [0x4]=0x004000EF; then done=1, busy=0, flash_cs=1.
- Bit-level probe after start -> mosi carries 0x03 then 0x000000 MSB first; flash_cs low for the entire transfer; flash_clk period 2 clk cycles.
- Hold ramio_busy=1 for 20 cycles at the first Write -> ramio_enable stays 0, flash_clk frozen at 0; write issued on the first cycle busy=0; the data matches the no-stall case.
- Full TransferBytes=4096 with the RAM model behind ramio -> 1024 writes; RAM read-back equals the flash image; done=1.
- Assert rst during Recv of the 3rd word -> flash_cs=1, all outputs at reset values, no further writes; a new start reloads correctly from word 0.
- start pulse while busy=1 -> ignored; write count unchanged; a start after done clears done and repeats the copy.
